// File: rtl/preempt_arbiter.sv
// preempt_arbiter: grants one emergency-preemption requester at a time.
// Each grant runs CLEAR (all-red) -> HOLD (grant asserted) -> COOL (requests ignored).
// All durations are counted in tick strobes, not clk cycles.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no owner; arbitrate round-robin as soon as any req is high
//   S_CLEAR | owner committed, controller forces all-red for CLEAR_T ticks
//   S_HOLD  | grant[owner] high; release on min-hold+drop or at MAX_HOLD
//   S_COOL  | all requests ignored for COOL_T ticks
module preempt_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CLEAR_T  = 5,
  parameter int MIN_HOLD = 10,
  parameter int MAX_HOLD = 60,
  parameter int COOL_T   = 8,
  parameter int TW       = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     clearing,
  output logic                     active,
  output logic                     timeout
);

  localparam int OW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] MAX_LAST   = TW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] COOL_LAST  = TW'(COOL_T - 1);
  localparam logic [TW-1:0] MIN_TICKS  = TW'(MIN_HOLD);

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             clearing_q, clearing_d;
  logic             active_q, active_d;
  logic             timeout_q, timeout_d;

  logic [OW-1:0]    winner;
  logic             found;
  logic             rel_norm;
  logic             rel_force;
  int               idx;

  // Round-robin pick: first set request searching upward from last+1, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_q) + i) % N_REQ;
      if (!found && req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Release conditions while holding; normal release needs no tick.
  always_comb begin
    rel_norm  = (timer_q >= MIN_TICKS) && !req[owner_q];
    rel_force = tick && (timer_q == MAX_LAST);
  end

  // Next-state, timer and owner bookkeeping.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (found) begin
          owner_d = winner;
          last_d  = winner;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (tick) begin
          if (timer_q == CLEAR_LAST) begin
            state_d = S_HOLD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (rel_norm || rel_force) begin
          state_d   = S_COOL;
          timer_d   = '0;
          // A forced release only counts as a timeout if the owner still wants the grant.
          timeout_d = rel_force && req[owner_q];
        end else if (tick) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COOL: begin
        if (tick) begin
          if (timer_q == COOL_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        owner_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with the transition.
  always_comb begin
    grant_d = '0;
    if (state_d == S_HOLD) begin
      grant_d[owner_d] = 1'b1;
    end
    clearing_d = (state_d == S_CLEAR);
    active_d   = (state_d == S_CLEAR) || (state_d == S_HOLD) || (state_d == S_COOL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      owner_q    <= '0;
      last_q     <= OW'(N_REQ - 1);
      grant_q    <= '0;
      clearing_q <= 1'b0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      clearing_q <= clearing_d;
      active_q   <= active_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign clearing = clearing_q;
  assign active   = active_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_preempt_arbiter.sv
// Directed bench for preempt_arbiter; expected values hand-computed per edge.
module tb_preempt_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner_id;
  logic       clearing;
  logic       active;
  logic       timeout;

  int tests  = 0;
  int fails  = 0;
  int to_cnt = 0;
  int ph     = 0;
  bit tick4  = 1'b0;

  always #5 clk = ~clk;

  preempt_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .req      (req),
    .grant    (grant),
    .owner_id (owner_id),
    .clearing (clearing),
    .active   (active),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: set tick for the coming edge, then sample 1 time unit after it.
  task automatic step();
    tick = tick4 ? (ph == 3) : 1'b1;
    ph = (ph + 1) % 4;
    @(posedge clk);
    #1;
    if (timeout === 1'b1) to_cnt++;
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    chk("grant_clear_excl", 32'((grant != 4'b0) && clearing), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0;
    tick  = 1'b1;

    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_clearing", 32'(clearing), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);

    // Single requester 1, held 20 cycles then dropped.
    to_cnt = 0;
    req = 4'b0010;
    step();                                   // edge 0
    chk("t1_clear_start", 32'(clearing), 32'd1);
    chk("t1_owner", 32'(owner_id), 32'd1);
    chk("t1_active", 32'(active), 32'd1);
    chk("t1_nogrant_clear", 32'(grant), 32'h0);
    steps(4);                                 // edge 4
    chk("t1_clear_last", 32'(clearing), 32'd1);
    step();                                   // edge 5
    chk("t1_grant_start", 32'(grant), 32'h2);
    chk("t1_clear_end", 32'(clearing), 32'd0);
    steps(14);                                // edge 19
    chk("t1_grant_held", 32'(grant), 32'h2);
    req = 4'b0;
    step();                                   // edge 20
    chk("t1_release", 32'(grant), 32'h0);
    chk("t1_cool_active", 32'(active), 32'd1);
    steps(7);                                 // edge 27
    chk("t1_cool_last", 32'(active), 32'd1);
    step();                                   // edge 28
    chk("t1_idle", 32'(active), 32'd0);
    chk("t1_no_timeout", 32'(to_cnt), 32'd0);

    // Two persistent requesters 0 and 2: forced releases, alternation.
    do_reset();
    to_cnt = 0;
    req = 4'b0101;
    step();                                   // edge 0
    chk("t2_clear", 32'(clearing), 32'd1);
    chk("t2_owner0", 32'(owner_id), 32'd0);
    steps(5);                                 // edge 5
    chk("t2_grant0", 32'(grant), 32'h1);
    steps(59);                                // edge 64
    chk("t2_grant0_last", 32'(grant), 32'h1);
    chk("t2_no_to_yet", 32'(timeout), 32'd0);
    step();                                   // edge 65
    chk("t2_forced", 32'(grant), 32'h0);
    chk("t2_timeout", 32'(timeout), 32'd1);
    chk("t2_cool", 32'(active), 32'd1);
    step();                                   // edge 66
    chk("t2_timeout_pulse", 32'(timeout), 32'd0);
    steps(7);                                 // edge 73
    chk("t2_idle", 32'(active), 32'd0);
    step();                                   // edge 74
    chk("t2_clear2", 32'(clearing), 32'd1);
    chk("t2_owner2", 32'(owner_id), 32'd2);
    steps(5);                                 // edge 79
    chk("t2_grant2", 32'(grant), 32'h4);
    steps(60);                                // edge 139
    chk("t2_forced2", 32'(grant), 32'h0);
    chk("t2_timeout2", 32'(timeout), 32'd1);
    steps(8);                                 // edge 147
    chk("t2_idle2", 32'(active), 32'd0);
    step();                                   // edge 148
    chk("t2_owner_back0", 32'(owner_id), 32'd0);
    steps(5);                                 // edge 153
    chk("t2_grant0_again", 32'(grant), 32'h1);
    chk("t2_to_count", 32'(to_cnt), 32'd2);

    // req[3] pulsed two cycles: full clear, minimum hold, then cool.
    do_reset();
    to_cnt = 0;
    req = 4'b1000;
    step();                                   // edge 0
    chk("t3_clear", 32'(clearing), 32'd1);
    chk("t3_owner3", 32'(owner_id), 32'd3);
    step();                                   // edge 1
    req = 4'b0;
    steps(4);                                 // edge 5
    chk("t3_grant", 32'(grant), 32'h8);
    steps(10);                                // edge 15
    chk("t3_min_hold", 32'(grant), 32'h8);
    step();                                   // edge 16
    chk("t3_release", 32'(grant), 32'h0);
    chk("t3_cool", 32'(active), 32'd1);
    chk("t3_no_timeout", 32'(to_cnt), 32'd0);

    // req[2] raised during cool: ignored until idle.
    steps(2);                                 // edge 18
    req = 4'b0100;
    steps(5);                                 // edge 23
    chk("t4_cool_ignores", 32'(clearing), 32'd0);
    chk("t4_cool_active", 32'(active), 32'd1);
    step();                                   // edge 24
    chk("t4_idle", 32'(active), 32'd0);
    chk("t4_idle_noclear", 32'(clearing), 32'd0);
    step();                                   // edge 25
    chk("t4_clear", 32'(clearing), 32'd1);
    chk("t4_owner2", 32'(owner_id), 32'd2);

    // Reset in the middle of a hold.
    steps(5);                                 // edge 30
    chk("t5_grant", 32'(grant), 32'h4);
    steps(3);                                 // edge 33
    reset = 1'b1;
    step();                                   // edge 34
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_active", 32'(active), 32'd0);
    chk("t5_rst_clear", 32'(clearing), 32'd0);
    chk("t5_rst_owner", 32'(owner_id), 32'd0);
    reset = 1'b0;
    req = 4'b1111;
    step();
    chk("t5_clear", 32'(clearing), 32'd1);
    chk("t5_owner0", 32'(owner_id), 32'd0);
    steps(5);
    chk("t5_grant0", 32'(grant), 32'h1);

    // Tick every 4th cycle; req[1] dropped after 3 hold ticks.
    do_reset();
    to_cnt = 0;
    tick4 = 1'b1;
    ph = 0;
    req = 4'b0010;
    step();                                   // edge 0, no tick
    chk("t6_clear", 32'(clearing), 32'd1);
    steps(18);                                // edge 18
    chk("t6_clear_frozen", 32'(clearing), 32'd1);
    chk("t6_nogrant", 32'(grant), 32'h0);
    step();                                   // edge 19, 5th tick
    chk("t6_grant", 32'(grant), 32'h2);
    chk("t6_clear_end", 32'(clearing), 32'd0);
    steps(12);                                // edge 31, 3rd hold tick
    req = 4'b0;
    steps(28);                                // edge 59, 10th hold tick
    chk("t6_min_hold", 32'(grant), 32'h2);
    step();                                   // edge 60
    chk("t6_release", 32'(grant), 32'h0);
    chk("t6_cool", 32'(active), 32'd1);
    chk("t6_no_timeout", 32'(to_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
